// File: rtl/alu_op_sequencer.sv
// Command front end for the 3-bit ALU: buffers requests in a small FIFO, issues one at a time,
// waits out the ALU's registered latency and returns result/carry on a valid/ready response port.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             bbclk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_a,
  input  logic [2:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [2:0]       alu_a,
  output logic [2:0]       alu_b,
  output logic [1:0]       alu_op_code,
  input  logic [5:0]       alu_op_out,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_data,
  output logic             rsp_carry,
  output logic [1:0]       rsp_op,
  output logic [CNT_W-1:0] cmd_count,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop, rsp_capture, rsp_clear;
  logic [7:0]       head;

  assign full      = (cmd_count == CNT_W'(FIFO_DEPTH));
  assign empty     = (cmd_count == '0);
  // Ready comes from the registered count only, so rsp_ready never reaches cmd_ready.
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    rsp_capture = 1'b0;
    rsp_clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        rsp_capture = 1'b1;
        state_nxt   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_clear = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge bbclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FIFO storage holds data only; occupancy and pointers carry the reset.
  always_ff @(posedge bbclk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge bbclk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cmd_count <= cmd_count + CNT_W'(1);
        2'b01:   cmd_count <= cmd_count - CNT_W'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // Issue stage: operands only change on a pop, so they stay put through ISSUE and WAIT.
  always_ff @(posedge bbclk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op_code <= '0;
    end else if (pop) begin
      alu_a       <= head[7:5];
      alu_b       <= head[4:2];
      alu_op_code <= head[1:0];
    end
  end

  // Response stage: capture at the end of WAIT, hold until accepted.
  always_ff @(posedge bbclk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_op    <= '0;
    end else if (rsp_capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_op_out;
      rsp_carry <= (alu_op_code == 2'b10) ? alu_carry_out : 1'b0;
      rsp_op    <= alu_op_code;
    end else if (rsp_clear) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a stand-in registered ALU plus a queue-based reference model
// checked against every DUT output after each clock edge.
module tb_alu_op_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  logic             bbclk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_a = '0;
  logic [2:0]       cmd_b = '0;
  logic [1:0]       cmd_op = '0;
  logic [2:0]       alu_a, alu_b;
  logic [1:0]       alu_op_code;
  logic [5:0]       alu_op_out = '0;
  logic             alu_carry_out = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [5:0]       rsp_data;
  logic             rsp_carry;
  logic [1:0]       rsp_op;
  logic [CNT_W-1:0] cmd_count;
  logic             busy;

  alu_op_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .bbclk(bbclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
    .alu_op_out(alu_op_out), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_op(rsp_op), .cmd_count(cmd_count), .busy(busy)
  );

  always #5 bbclk = ~bbclk;

  // Stand-in ALU: registered result; carry only updates on ADD, otherwise it goes stale.
  always_ff @(posedge bbclk) begin
    logic [3:0] sum4;
    sum4 = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_op_code)
      2'b00: alu_op_out <= {3'b000, alu_a & alu_b};
      2'b01: alu_op_out <= {3'b000, alu_a | alu_b};
      2'b10: begin
        alu_op_out    <= {2'b00, sum4};
        alu_carry_out <= sum4[3];
      end
      default: alu_op_out <= {3'b000, alu_a} * {3'b000, alu_b};
    endcase
  end

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
  } cmd_t;

  int   n_chk = 0;
  int   n_bad = 0;

  // Reference model: pending queue, cycles left until the issued command's result appears,
  // and the response currently held.
  cmd_t q[$];
  cmd_t m_alu;
  int   cd;
  bit   rv;
  int   m_data, m_carry, m_op;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int f_res(input cmd_t c);
    case (c.op)
      2'd0:    return int'(c.a & c.b);
      2'd1:    return int'(c.a | c.b);
      2'd2:    return int'(c.a) + int'(c.b);
      default: return int'(c.a) * int'(c.b);
    endcase
  endfunction

  task automatic model_edge();
    bit   ready, do_pop;
    cmd_t c;
    if (rst) begin
      q.delete();
      cd = 0; rv = 0; m_alu = '0;
      m_data = 0; m_carry = 0; m_op = 0;
      return;
    end
    ready  = q.size() < FIFO_DEPTH;
    do_pop = 0;
    if (cd == 2) cd = 1;
    else if (cd == 1) begin
      cd = 0; rv = 1;
      m_data  = f_res(m_alu);
      m_carry = (m_alu.op == 2'd2 && int'(m_alu.a) + int'(m_alu.b) > 7) ? 1 : 0;
      m_op    = int'(m_alu.op);
    end
    else if (!rv) do_pop = q.size() > 0;
    else if (rsp_ready) begin
      rv = 0;
      do_pop = q.size() > 0;
    end
    if (do_pop) begin
      m_alu = q.pop_front();
      cd = 2;
    end
    if (cmd_valid && ready) begin
      c.a = cmd_a; c.b = cmd_b; c.op = cmd_op;
      q.push_back(c);
    end
  endtask

  task automatic check_all();
    check_eq("rsp_valid", int'(rsp_valid), int'(rv));
    check_eq("rsp_data", int'(rsp_data), m_data);
    check_eq("rsp_carry", int'(rsp_carry), m_carry);
    check_eq("rsp_op", int'(rsp_op), m_op);
    check_eq("alu_a", int'(alu_a), int'(m_alu.a));
    check_eq("alu_b", int'(alu_b), int'(m_alu.b));
    check_eq("alu_op_code", int'(alu_op_code), int'(m_alu.op));
    check_eq("cmd_count", int'(cmd_count), q.size());
    check_eq("cmd_ready", int'(cmd_ready), (!rst && q.size() < FIFO_DEPTH) ? 1 : 0);
    check_eq("busy", int'(busy), (cd != 0 || rv || q.size() > 0) ? 1 : 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge bbclk);
    #1;
    check_all();
  endtask

  task automatic set_cmd(input bit v, input int a, input int b, input int op);
    cmd_valid = v;
    cmd_a = 3'(a); cmd_b = 3'(b); cmd_op = 2'(op);
  endtask

  task automatic single(input string tag, input int a, input int b, input int op,
                        input int exp_data, input int exp_carry);
    int n;
    rsp_ready = 1'b1;
    set_cmd(1, a, b, op);
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    check_eq({tag, "_lat"}, n, 3);
    check_eq({tag, "_data"}, int'(rsp_data), exp_data);
    check_eq({tag, "_carry"}, int'(rsp_carry), exp_carry);
    check_eq({tag, "_op"}, int'(rsp_op), op);
    step();
  endtask

  initial begin
    int   seen;
    int   carr[$];
    cd = 0; rv = 0; m_alu = '0; m_data = 0; m_carry = 0; m_op = 0;

    // Reset values, then release
    rst = 1'b1;
    step();
    step();
    check_eq("rst_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", int'(cmd_ready), 1);
    step();

    // Single ops with latency
    single("and", 5, 3, 0, 1, 0);
    single("or", 5, 3, 1, 7, 0);
    single("mul", 7, 7, 3, 49, 0);
    single("add", 3, 2, 2, 5, 0);

    // Fill with responses blocked, then hold backpressure, then drain
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1, i + 1, 7 - i, i % 4);
      step();
    end
    cmd_valid = 1'b0;
    check_eq("fill_count", int'(cmd_count), FIFO_DEPTH);
    check_eq("fill_ready", int'(cmd_ready), 0);
    for (int i = 0; i < 10; i++) step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_eq("drain_busy", int'(busy), 0);

    // Continuous stream: pushes and pops overlap and pointers wrap
    for (int i = 0; i < 30; i++) begin
      set_cmd(1, $urandom_range(7), $urandom_range(7), $urandom_range(3));
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Reset while a command sits in WAIT with two queued behind it
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, i + 2, i + 3, 2);
      step();
    end
    cmd_valid = 1'b0;
    check_eq("pre_rst_count", int'(cmd_count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", int'(rsp_valid), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check_eq("no_stale_rsp", seen, 0);

    // ADD with carry, then MUL while the ALU carry is stale
    set_cmd(1, 7, 7, 2);
    step();
    set_cmd(1, 2, 3, 3);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid) carr.push_back(int'(rsp_carry));
    end
    check_eq("carry_n", carr.size(), 2);
    if (carr.size() == 2) begin
      check_eq("carry_add", carr[0], 1);
      check_eq("carry_mul", carr[1], 0);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      set_cmd($urandom_range(99) < 60, $urandom_range(7), $urandom_range(7), $urandom_range(3));
      rsp_ready = ($urandom_range(99) < 55);
      rst = ($urandom_range(99) < 2);
      step();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_eq("final_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
